// File: rtl/event_latch16_if.sv
// Event-serving handshake between event_latch16 (master) and its consumer (slave).
interface event_latch16_if #(
  parameter int ID_W = 4
);
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ready;

  modport master (output irq_valid, output irq_id, input irq_ready);
  modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/event_latch16.sv
// Sticky 16-line rising-edge capture with lowest-index-first serving over valid/ready.
// Optional EVENT_LATCH16_SYNC_EN adds a two-flop input synchronizer ahead of edge detect.
//
// state   | meaning
// IDLE    | nothing offered; pick lowest set bit of pend_masked
// PRESENT | irq_id offered, held until irq_ready
module event_latch16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ev_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] pend_masked,
  output logic [WIDTH-1:0] overflow,
  event_latch16_if.master  irq
);
  localparam int ID_W = $clog2(WIDTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [WIDTH-1:0] ev_s;
  logic [WIDTH-1:0] ev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] sw_clr;
  logic [WIDTH-1:0] hs_clr;
  logic [WIDTH-1:0] clr;
  logic             hs;
  logic             valid_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  low_id;

`ifdef EVENT_LATCH16_SYNC_EN
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ev_in;
      sync2 <= sync1;
    end
  end

  assign ev_s = sync2;
`else
  assign ev_s = ev_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ev_q <= '0;
    else     ev_q <= ev_s;
  end

  assign rise   = ev_s & ~ev_q;
  assign hs     = valid_q & irq.irq_ready;
  assign sw_clr = clr_en ? clr_mask : '0;
  assign hs_clr = hs ? (WIDTH'(1) << id_q) : '0;
  assign clr    = sw_clr | hs_clr;

  // Set dominates clear so an edge coinciding with its own clear is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clr) | rise;
      overflow <= (overflow & ~sw_clr) | (rise & pending & ~clr);
    end
  end

  assign pend_masked = pending & mask;

  always_comb begin
    low_id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_masked[i]) low_id = ID_W'(i);
    end
  end

  // The offer is never withdrawn once made, even if its bit is cleared or masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend_masked) begin
            state   <= PRESENT;
            valid_q <= 1'b1;
            id_q    <= low_id;
          end
        end
        PRESENT: begin
          if (irq.irq_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq.irq_valid = valid_q;
  assign irq.irq_id    = id_q;
endmodule

// File: tb/tb_event_latch16.sv
// Scoreboard bench for event_latch16: a set-based reference model queues expected
// state and served ids; separate monitors pop and compare against the DUT.
module tb_event_latch16;
`ifdef EVENT_LATCH16_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ev_in = '0;
  logic [15:0] mask = '0;
  logic        clr_en = 1'b0;
  logic [15:0] clr_mask = '0;
  logic [15:0] pending;
  logic [15:0] pend_masked;
  logic [15:0] overflow;

  event_latch16_if #(.ID_W(4)) irq_bus ();

  event_latch16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_in       (ev_in),
    .mask        (mask),
    .clr_en      (clr_en),
    .clr_mask    (clr_mask),
    .pending     (pending),
    .pend_masked (pend_masked),
    .overflow    (overflow),
    .irq         (irq_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pend;
    logic [15:0] ovf;
    logic        valid;
    logic [3:0]  id;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] hs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sets of pending/overflowed lines plus the current offer.
  logic [15:0] m_prev;
  logic [15:0] m_pend;
  logic [15:0] m_ovf;
  logic        m_valid;
  logic [3:0]  m_id;
  logic [15:0] m_pipe[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic model_clear();
    m_prev  = '0;
    m_pend  = '0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_id    = '0;
    m_pipe.delete();
    for (int i = 0; i < LAT; i++) m_pipe.push_back(16'h0000);
  endtask

  // Called at posedge+2: drive inputs, predict the next edge, then advance one cycle.
  task automatic step(input logic [15:0] ev, input logic [15:0] mk, input logic ce,
                      input logic [15:0] cm, input logic rdy);
    logic [15:0] seen, rise_m, sw, clr_m, visible;
    logic        hs_m;
    exp_t        e;
    ev_in = ev;
    mask = mk;
    clr_en = ce;
    clr_mask = cm;
    irq_bus.irq_ready = rdy;
    m_pipe.push_back(ev);
    seen = m_pipe.pop_front();
    rise_m = seen & ~m_prev;
    m_prev = seen;
    hs_m = m_valid && rdy;
    sw = ce ? cm : 16'h0000;
    clr_m = sw | (hs_m ? (16'(1) << m_id) : 16'h0000);
    if (hs_m) hs_q.push_back(m_id);
    visible = m_pend & mk;
    m_ovf  = (m_ovf & ~sw) | (rise_m & m_pend & ~clr_m);
    m_pend = (m_pend & ~clr_m) | rise_m;
    if (!m_valid) begin
      if (visible != 0) begin
        m_valid = 1'b1;
        m_id = lowest(visible);
      end
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    e.pend = m_pend;
    e.ovf = m_ovf;
    e.valid = m_valid;
    e.id = m_id;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [15:0] ev_hold);
    rst = 1'b1;
    ev_in = ev_hold;
    clr_en = 1'b0;
    irq_bus.irq_ready = 1'b0;
    #1;
    check("rst_pending", pending, 16'h0000);
    check("rst_overflow", overflow, 16'h0000);
    check("rst_pend_masked", pend_masked, 16'h0000);
    check("rst_irq_valid", 16'(irq_bus.irq_valid), 16'h0000);
    check("rst_irq_id", 16'(irq_bus.irq_id), 16'h0000);
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : state_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pending", pending, e.pend);
        check("overflow", overflow, e.ovf);
        check("irq_valid", 16'(irq_bus.irq_valid), 16'(e.valid));
        if (e.valid) check("irq_id", 16'(irq_bus.irq_id), 16'(e.id));
        check("pend_masked", pend_masked, e.pend & mask);
      end
    end
  end

  initial begin : handshake_monitor
    forever begin
      @(negedge clk);
      if (!rst && irq_bus.irq_valid && irq_bus.irq_ready) begin
        if (hs_q.size() == 0) check("hs_unexpected", 16'(irq_bus.irq_id), 16'hFFFF);
        else check("hs_id", 16'(irq_bus.irq_id), 16'(hs_q.pop_front()));
      end
    end
  end

  initial begin : stimulus
    irq_bus.irq_ready = 1'b0;
    do_reset(16'h0000);

    repeat (3) step(16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    check("idle_pending", pending, 16'h0000);
    check("idle_pend_masked", pend_masked, 16'h0000);
    check("idle_or16_y", 16'(|pend_masked), 16'h0000);

    repeat (LAT + 1) step(16'h0021, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    check("two_ev_pending", pending, 16'h0021);
    repeat (6) step(16'h0021, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    check("two_ev_served", pending, 16'h0000);

    step(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    step(16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b1);
    step(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    step(16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b1);
    repeat (LAT + 1) step(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    check("ovf_pending", pending, 16'h0004);
    check("ovf_overflow", overflow, 16'h0004);
    step(16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b1);
    check("swclr_pending", pending, 16'h0000);
    check("swclr_overflow", overflow, 16'h0000);

    step(16'h0008, 16'h0008, 1'b0, 16'h0000, 1'b0);
    repeat (LAT + 2) step(16'h0000, 16'h0008, 1'b0, 16'h0000, 1'b0);
    check("hold_valid", 16'(irq_bus.irq_valid), 16'h0001);
    check("hold_id", 16'(irq_bus.irq_id), 16'h0003);
    step(16'h0000, 16'h0008, 1'b1, 16'h0008, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      check("hold_valid_stable", 16'(irq_bus.irq_valid), 16'h0001);
      check("hold_id_stable", 16'(irq_bus.irq_id), 16'h0003);
    end
    step(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1);
    check("hold_bit3_clear", 16'(pending[3]), 16'h0000);
    check("hold_done_valid", 16'(irq_bus.irq_valid), 16'h0000);

`ifndef EVENT_LATCH16_SYNC_EN
    step(16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b0);
    repeat (2) step(16'h0000, 16'h0080, 1'b0, 16'h0000, 1'b0);
    step(16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1);
    check("set_dom_pending7", 16'(pending[7]), 16'h0001);
    check("set_dom_overflow7", 16'(overflow[7]), 16'h0000);
`endif
    repeat (4) step(16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1);

    step(16'h8001, 16'h0000, 1'b0, 16'h0000, 1'b0);
    repeat (LAT + 1) step(16'h8001, 16'h0000, 1'b0, 16'h0000, 1'b0);
    repeat (2) step(16'h8001, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    check("pre_rst_valid", 16'(irq_bus.irq_valid), 16'h0001);
    check("pre_rst_pending", pending, 16'h8001);
    do_reset(16'h0001);
    repeat (LAT + 1) step(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    check("post_rst_pending", pending, 16'h0001);

    repeat (400) begin
      step(16'($urandom) & 16'($urandom) & 16'($urandom),
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF,
           1'($urandom_range(0, 9) == 0),
           16'($urandom),
           1'($urandom_range(0, 1)));
    end
    repeat (40) step(16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    check("exp_q_drained", 16'(exp_q.size()), 16'h0000);
    check("hs_q_drained", 16'(hs_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/event_latch16.md
# event_latch16

Sixteen-input sticky event capture stage that sits directly upstream of `or16`. It detects rising edges on 16 event lines and holds them as pending bits. The masked pending vector drives `or16.a`, whose `y` is the "any event pending" summary. It also serves pending events one at a time, lowest index first, over a valid/ready handshake, and clears each bit on acceptance.

## Interface
- Parameters:
  - `WIDTH`, default 16: number of event lines. Fixed at 16 for this design; `irq_id` width is $clog2(WIDTH).
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `rst` in 1: reset, asynchronous and active-high.
  - `ev_in` in 16: raw event levels; a 0→1 transition is an event.
  - `mask` in 16: per-line enable for serving and for `pend_masked`; does not gate capture.
  - `clr_en` in 1: software clear strobe, one cycle.
  - `clr_mask` in 16: bits of `pending` and `overflow` to clear when `clr_en`=1.
  - `pending` out 16: raw sticky pending bits, registered.
  - `pend_masked` out 16: `pending & mask`, combinational; connects to `or16.a`.
  - `overflow` out 16: sticky; an edge arrived while that bit was already pending.
  - `irq_valid` out 1: an event index is being offered.
  - `irq_id` out 4: index being offered; stable while `irq_valid`=1.
  - `irq_ready` in 1: consumer accepts; handshake = `irq_valid & irq_ready` at a rising edge.

## Operation
- Edge detect: `ev_q <= ev_s` every cycle; `rise = ev_s & ~ev_q`. Without the sync macro, `ev_s` = `ev_in`. `ev_q` resets to 0, so a line already high when reset releases counts as an event on the first edge.
- Clear vector `clr` = (`clr_mask` if `clr_en`) | (onehot(`irq_id`) if handshake).
- `pending <= (pending & ~clr) | rise`. Set dominates: a rise and a clear of the same bit in one cycle leaves the bit set, so no event is lost.
- `overflow[i] <= overflow[i] & ~(clr_en & clr_mask[i]) | (rise[i] & pending[i] & ~clr[i])`. A handshake never clears `overflow`.
- Serving FSM, 2 states:
  - IDLE (`irq_valid`=0): if `|pend_masked`, load `irq_id` with the lowest set index of `pend_masked` and go to PRESENT.
  - PRESENT (`irq_valid`=1): hold `irq_id` and stay until `irq_ready`. On handshake, clear that pending bit and return to IDLE. IDLE costs one bubble cycle between grants.
  - If the offered bit is cleared by `clr_en` or masked off while in PRESENT, the offer is not withdrawn. `irq_valid` and `irq_id` hold until handshake, and the handshake clear is then a no-op on that bit.
- `mask` changes affect `pend_masked` immediately and the FSM choice at the next IDLE evaluation.

## Timing
- Reset values: `pending`=0, `overflow`=0, `irq_valid`=0, `irq_id`=0, `ev_q`=0, FSM=IDLE, sync flops=0. `pend_masked`=0 while in reset.
- Reset mid-offer drops `irq_valid` asynchronously; nothing pending survives.
- `ev_in` 0→1 before edge k: `pending` bit is visible after edge k; `pend_masked`/`or16.y` in the same cycle; `irq_valid` after edge k+1.
- Handshake at edge m: bit cleared and `irq_valid`=0 after m; earliest next `irq_valid` after m+1.
- Throughput: one served event per 2 cycles with `irq_ready` held high.
- Held-high input: one event only; a new event needs a return to 0 for at least one sampled cycle.

## Configuration
- `EVENT_LATCH16_SYNC_EN` defined: `ev_in` passes through a two-flop synchronizer (reset 0) before edge detect. All `ev_in`-referenced latencies grow by 2 cycles, so pending is visible after edge k+2.
- Not defined: `ev_s` = `ev_in` directly, with the latencies above. `ev_in` must then be synchronous to `clk`.

## Test plan
- Reset, then `ev_in`=0x0000, `mask`=0xFFFF → `pending`=0, `pend_masked`=0, `irq_valid`=0; `or16.y`=0.
- `ev_in`=0x0000→0x0021 at edge k, `irq_ready`=1 → `pending`=0x0021 after k. Offer `irq_id`=0, then after a bubble `irq_id`=5; `pending`=0x0000 after the second handshake.
- `ev_in` 0x0004 pulse twice without serving (`mask`=0) → `pending`=0x0004, `overflow`=0x0004. Then `clr_en`=1 with `clr_mask`=0x0004 → both 0.
- Offer `irq_id`=3 with `irq_ready`=0 for 5 cycles, while `clr_en` clears bit 3 and `mask` drops bit 3 → `irq_valid`/`irq_id` stay stable. Handshake then completes and `pending[3]` stays 0.
- Rise on bit 7 in the same cycle as the handshake clearing bit 7 → `pending[7]`=1 afterwards and `overflow[7]`=0.
- Assert `rst` while `irq_valid`=1 and `pending`=0x8001 → all outputs go to 0 immediately. With `ev_in`=0x0001 held at release, `pending`=0x0001 after the first edge; the same check with `EVENT_LATCH16_SYNC_EN` shows a 2-cycle delay.
